ring_counter_param: RTL and testbench
=====================================

// Module: ring_counter_param
//
// PURPOSE
// - Parametrised synchronous shift-sequence counter; successor of the fixed 4-bit 1->2->4->8 counter.
// - Generalised to any WIDTH, with two modes (one-hot ring / Johnson twisted ring) and up/down direction.
// - Adds an explicit load strobe, a count enable and a registered wrap pulse.
// - Used as a sequencer, phase generator or LED chaser driven from one clock domain.
//
// PARAMETERS
// - WIDTH  4  counter width in bits; must be >= 2.
// - SEED   1  reset value and ring zero-recovery value; WIDTH bits; must be one-hot.
//
// PORTS
// - clk       in   1      clock; all state updates on rising edge.
// - reset     in   1      asynchronous, active-high reset.
// - en        in   1      step enable; 1 = advance one step on this edge.
// - load      in   1      parallel-load strobe; takes priority over en.
// - load_val  in   WIDTH  value captured when load=1.
// - dir       in   1      0 = up (toward MSB), 1 = down (toward LSB).
// - mode      in   1      0 = one-hot ring, 1 = Johnson.
// - count     out  WIDTH  current counter state, registered.
// - wrap      out  1      registered pulse, high while count shows a wrapped value.
// - load_err  out  1      registered pulse; rejected load (see CONFIGURATION).
//
// BEHAVIOUR
// - Clock and reset: one clock, clk; reset is asynchronous and active-high.
// - Reset values: count=SEED, wrap=0, load_err=0. Reset is independent of mode and dir.
// - Reset mid-operation clears state immediately; the first step after release starts from SEED.
// - Priority per edge: reset > load > en > hold.
// - Load: count<=load_val next edge, wrap<=0. Load is a 1-cycle latency path.
// - Hold (en=0, load=0): count and its value held; wrap<=0, load_err<=0.
// - Ring up: count<=rotate-left(count). Example WIDTH=4: 0001->0010->0100->1000->0001.
// - Ring down: count<=rotate-right(count).
// - Ring with count==0 and en=1: count<=SEED (self-recovery), wrap<=0.
// - Ring with a non-one-hot count (loaded without the check): the pattern is rotated as is.
// - Johnson up: count<={count[WIDTH-2:0], ~count[WIDTH-1]}.
//   - Sequence has 2*WIDTH states: 0000->0001->0011->0111->1111->1110->1100->1000->0000.
// - Johnson down: count<={~count[0], count[WIDTH-1:1]}; this is the exact reverse sequence.
// - wrap<=1 only on an enabled step where:
//   - ring up with count==1<<(WIDTH-1);
//   - ring down with count==1;
//   - Johnson up with count=={1'b1,{WIDTH-1{1'b0}}};
//   - Johnson down with count==0.
//   - wrap is asserted in the same cycle count shows the post-wrap value, otherwise 0.
// - dir or mode change: takes effect on the next enabled step; no re-seed; the current count is reinterpreted.
// - load and en together: load wins; no step occurs and wrap=0.
//
// CONFIGURATION
// - Macro RING_COUNTER_LOAD_CHECK_EN.
// - Defined: load_val is validated before capture.
//   - mode=0: the value must be one-hot.
//   - mode=1: the value must be a legal Johnson state, i.e. 0...01...1 or 1...10...0, including all-0 and all-1.
//   - Illegal value: count holds, wrap<=0, load_err<=1 for exactly one cycle.
// - Undefined: every load_val is accepted and load_err is tied to 0.
//
// TESTING (WIDTH=4, SEED=0001)
// - Reset, then en=1, mode=0, dir=0 for 8 edges -> count 0010,0100,1000,0001,...; wrap=1 only when count=0001.
// - mode=1, dir=0, from 0000, 8 steps -> 0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 only at the final 0000.
//   - Then dir=1 -> 1000; wrap=1.
// - load=1, en=1, load_val=0100 -> count=0100, wrap=0. Then dir=1, en=1 -> 0010.
//   - Assert reset async mid-cycle -> count=0001 before the next edge.
// - load 0000, mode=0, en=1 -> count=0001 (recovery), wrap=0.
//   - en=0 for 3 edges -> count held.
// - With RING_COUNTER_LOAD_CHECK_EN: mode=0, load 0110 -> count unchanged, load_err=1 for 1 cycle.
//   - mode=1, load 1100 -> accepted.
//   - Without the macro: 0110 loaded and rotates to 1100; load_err=0.

Source files
------------

// File: rtl/ring_counter_param_if.sv
// Control and status bundle for ring_counter_param: step/load controls in, count and pulses out.
// master drives the controls; slave is the counter itself.
interface ring_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, load, load_val, dir, mode,
        input  count, wrap, load_err
    );

    modport slave (
        input  en, load, load_val, dir, mode,
        output count, wrap, load_err
    );
endinterface

// File: rtl/ring_counter_param.sv
// Parametrised one-hot ring / Johnson counter with up/down, load, enable and registered wrap pulse.
// Latency: one edge for load and step; no backpressure. Optional load validation: RING_COUNTER_LOAD_CHECK_EN.
module ring_counter_param #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                reset,
    ring_counter_param_if.slave bus
);

    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] ring_up, ring_dn, john_up, john_dn;
    logic             load_ok;

    assign ring_up = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    assign ring_dn = {count_q[0], count_q[WIDTH-1:1]};
    assign john_up = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
    assign john_dn = {~count_q[0], count_q[WIDTH-1:1]};

`ifdef RING_COUNTER_LOAD_CHECK_EN
    function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] v_m1;
        v_m1 = v - LSB_ONLY;
        return (v != ALL_ZERO) && ((v & v_m1) == ALL_ZERO);
    endfunction

    // Legal Johnson states are a run of ones anchored at either end (0..01..1 or 1..10..0).
    function automatic logic is_johnson(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] v_p1, nv, nv_p1;
        v_p1  = v + LSB_ONLY;
        nv    = ~v;
        nv_p1 = nv + LSB_ONLY;
        return ((v & v_p1) == ALL_ZERO) || ((nv & nv_p1) == ALL_ZERO);
    endfunction

    assign load_ok = bus.mode ? is_johnson(bus.load_val) : is_one_hot(bus.load_val);
`else
    assign load_ok = 1'b1;
`endif

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                count_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (!bus.mode) begin
                // An empty ring would never advance, so restart it from the seed.
                if (count_q == ALL_ZERO) begin
                    count_d = SEED;
                end else if (!bus.dir) begin
                    count_d = ring_up;
                    wrap_d  = (count_q == MSB_ONLY);
                end else begin
                    count_d = ring_dn;
                    wrap_d  = (count_q == LSB_ONLY);
                end
            end else begin
                if (!bus.dir) begin
                    count_d = john_up;
                    wrap_d  = (count_q == MSB_ONLY);
                end else begin
                    count_d = john_dn;
                    wrap_d  = (count_q == ALL_ZERO);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= SEED;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench for ring_counter_param at WIDTH=4, SEED=0001; expectations follow RING_COUNTER_LOAD_CHECK_EN.
module tb_ring_counter_param;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ring_counter_param_if #(.WIDTH(4)) bus ();

    ring_counter_param #(.WIDTH(4), .SEED(4'b0001)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'b0000;
        bus.dir      = 1'b0;
        bus.mode     = 1'b0;
        #12;
        checks++;
        if (bus.count !== 4'b0001) begin
            errors++; $display("FAIL reset_count: got %b want 0001", bus.count);
        end
        checks++;
        if (bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: wrap=%b load_err=%b want 0 0", bus.wrap, bus.load_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_ring_up();
        logic [3:0] exp_c [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.mode = 1'b0;
        bus.dir  = 1'b0;
        bus.en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.count !== exp_c[i] || bus.wrap !== (exp_c[i] == 4'b0001)) begin
                errors++;
                $display("FAIL ring_up[%0d]: count=%b wrap=%b want %b %b",
                         i, bus.count, bus.wrap, exp_c[i], (exp_c[i] == 4'b0001));
            end
        end
    endtask

    task automatic test_johnson();
        logic [3:0] exp_c [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
        bus.mode     = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'b0000;
        step();
        checks++;
        if (bus.count !== 4'b0000) begin
            errors++; $display("FAIL johnson_load0: got %b want 0000", bus.count);
        end
        bus.load = 1'b0;
        bus.en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.count !== exp_c[i] || bus.wrap !== (i == 7)) begin
                errors++;
                $display("FAIL johnson_up[%0d]: count=%b wrap=%b want %b %b",
                         i, bus.count, bus.wrap, exp_c[i], (i == 7));
            end
        end
        bus.dir = 1'b1;
        step();
        checks++;
        if (bus.count !== 4'b1000 || bus.wrap !== 1'b1) begin
            errors++; $display("FAIL johnson_down_wrap: count=%b wrap=%b want 1000 1", bus.count, bus.wrap);
        end
        bus.en = 1'b0;
        step();
        checks++;
        if (bus.count !== 4'b1000 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL hold_clears_wrap: count=%b wrap=%b want 1000 0", bus.count, bus.wrap);
        end
        bus.en = 1'b1;
        step();
        checks++;
        if (bus.count !== 4'b1100 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL johnson_down: count=%b wrap=%b want 1100 0", bus.count, bus.wrap);
        end
    endtask

    task automatic test_load_priority();
        logic [3:0] exp_c [3] = '{4'b0010, 4'b0001, 4'b1000};
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        bus.en       = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'b0100;
        step();
        checks++;
        if (bus.count !== 4'b0100 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL load_wins: count=%b wrap=%b want 0100 0", bus.count, bus.wrap);
        end
        bus.load = 1'b0;
        bus.dir  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.count !== exp_c[i] || bus.wrap !== (i == 2)) begin
                errors++;
                $display("FAIL ring_down[%0d]: count=%b wrap=%b want %b %b",
                         i, bus.count, bus.wrap, exp_c[i], (i == 2));
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        checks++;
        if (bus.count !== 4'b0100) begin
            errors++; $display("FAIL pre_reset_step: got %b want 0100", bus.count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== 4'b0001 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%b wrap=%b load_err=%b want 0001 0 0",
                     bus.count, bus.wrap, bus.load_err);
        end
        reset   = 1'b0;
        bus.dir = 1'b0;
        step();
        checks++;
        if (bus.count !== 4'b0010) begin
            errors++; $display("FAIL post_reset_step: got %b want 0010", bus.count);
        end
    endtask

    task automatic test_recovery();
        bus.mode     = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'b0000;
        bus.en       = 1'b1;
        step();
        checks++;
        if (bus.count !== 4'b0000) begin
            errors++; $display("FAIL load_zero: got %b want 0000", bus.count);
        end
        bus.load = 1'b0;
        bus.mode = 1'b0;
        step();
        checks++;
        if (bus.count !== 4'b0001 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL ring_recovery: count=%b wrap=%b want 0001 0", bus.count, bus.wrap);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.count !== 4'b0001 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: count=%b wrap=%b load_err=%b want 0001 0 0",
                         i, bus.count, bus.wrap, bus.load_err);
            end
        end
    endtask

    task automatic test_load_check();
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'b0110;
        step();
`ifdef RING_COUNTER_LOAD_CHECK_EN
        checks++;
        if (bus.count !== 4'b0001 || bus.load_err !== 1'b1) begin
            errors++; $display("FAIL reject_load: count=%b load_err=%b want 0001 1", bus.count, bus.load_err);
        end
        bus.load = 1'b0;
        step();
        checks++;
        if (bus.count !== 4'b0001 || bus.load_err !== 1'b0) begin
            errors++; $display("FAIL load_err_pulse: count=%b load_err=%b want 0001 0", bus.count, bus.load_err);
        end
`else
        checks++;
        if (bus.count !== 4'b0110 || bus.load_err !== 1'b0) begin
            errors++; $display("FAIL accept_load: count=%b load_err=%b want 0110 0", bus.count, bus.load_err);
        end
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step();
        checks++;
        if (bus.count !== 4'b1100 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL rotate_non_onehot: count=%b wrap=%b load_err=%b want 1100 0 0",
                     bus.count, bus.wrap, bus.load_err);
        end
`endif
        bus.mode     = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'b1100;
        step();
        checks++;
        if (bus.count !== 4'b1100 || bus.load_err !== 1'b0) begin
            errors++; $display("FAIL johnson_load: count=%b load_err=%b want 1100 0", bus.count, bus.load_err);
        end
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step();
        checks++;
        if (bus.count !== 4'b1000 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL johnson_after_load: count=%b wrap=%b want 1000 0", bus.count, bus.wrap);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ring_up();
        test_johnson();
        test_load_priority();
        test_async_reset();
        test_recovery();
        test_load_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
